apd_timer_all: RTL and testbench
================================

Name: apd_timer_all

Overview:
- Photon time-tagger for four APD detector inputs.
- Synchronises the detector strobes, timestamps strobe rising edges and level changes against a free-running 38-bit counter, and emits one 47-bit record per event cycle.
- Configured over a simple write-only register bus.
- Sits between the detector front-end pins and the downstream record FIFO/USB packer.

Parameters:
- N_CH, 4, number of detector channels.
- TS_W, 38, timestamp counter width.
- REC_W, 47, record width; must equal TS_W + 2*N_CH + 1.

Ports:
- clk  input  1  single system clock; all logic, including the register bus, is on this clock.
- reset_n  input  1  asynchronous active-low reset.
- strobe_in  input  4  raw asynchronous detector pulses; each pulse is guaranteed at least one clk period wide.
- reg_addr  input  16  register address.
- reg_data  input  32  register write data.
- reg_wr  input  1  write strobe, sampled on every clk edge.
- record_rdy  output  1  one-cycle valid pulse for record.
- record  output  47  event record.

Behaviour:
- Reset: all registers, the counter, the synchronisers, record and record_rdy go to 0.
- Register write: at each clk edge with reg_wr=1, reg_data is written to the register at reg_addr. Repeated writes are idempotent. Unmapped addresses are ignored. There is no readback.
- 0x03 CTRL:
  - bit0 counter_run: counter increments by 1 each cycle while set.
  - bit1 events_en: record generation enabled.
  - bit2 counter_reset: while set, counter is held at 0 and in-flight events are discarded. This bit has priority over bit0.
- 0x04 STROBE_EN[3:0]: per-channel rising-edge capture enable.
- 0x05 DELTA_EN[3:0]: per-channel level-change (both edges) capture enable.
- Per-channel conditioning:
  - 2-FF synchroniser, then a previous-value register.
  - rise = s & ~p; change = s ^ p.
- Event cycle: any (rise & STROBE_EN) or (change & DELTA_EN) is nonzero, and events_en=1.
- Record format, registered and presented one cycle after the event cycle:
  - [37:0] counter value in the event cycle.
  - [41:38] strobe bits (rise & STROBE_EN).
  - [45:42] delta bits (change & DELTA_EN).
  - [46] wrap flag.
- Latency: the first clk edge sampling strobe_in=1 is edge 0. s becomes valid after edge 1, rise is seen in cycle 2, and record_rdy is high for exactly one cycle after edge 3.
- Wrap: when the counter rolls from all-ones to 0 with events_en=1, a record is emitted with bit46=1 and timestamp 0. If a channel event falls in the same cycle, it is merged into that same record.
- Simultaneous channels: events on the same cycle are combined into one record with multiple bits set.
- Flow control: none. The downstream side must accept one record per cycle.
- Disabling events_en or a channel mask mid-pulse suppresses the record. The enables are evaluated in the event cycle.
- record holds its last value when record_rdy=0.

Decomposition:
- Shared package apd_timer_pkg holds:
  - address constants REG_CTRL=0x03, REG_STROBE_EN=0x04, REG_DELTA_EN=0x05;
  - CTRL bit indices;
  - N_CH, TS_W, REC_W;
  - record field offsets.
- One sub-module, apd_input_cond: synchroniser, previous-value register and rise/change outputs for N_CH channels.

Test Plan:
- Reset, then write 0x04=0x00, 0x05=0x00, 0x03=0x04, 0x03=0x00, 0x04=0x0F, 0x03=0x03. Pulse ch0 5ns every 205ns and ch1 5ns every 35ns (clk 4ns) -> one record per pulse; bits[41:38]=0001 or 0010; timestamps strictly increasing with deltas matching pulse spacing ±1 cycle.
- record_rdy must pulse exactly 3 cycles after the first edge sampling strobe_in=1. It must stay low with 0x03=0x00, and also with STROBE_EN=0.
- DELTA_EN=0x1, STROBE_EN=0, one ch0 pulse of 3 cycles -> two records with bits[45:42]=0001, timestamps 3 apart.
- ch0 and ch1 rising on the same clk edge -> single record with strobe bits 0011.
- Preload a condition near wrap (use a reduced TS_W in the bench) -> record with bit46=1, timestamp 0. With a concurrent strobe, bit46=1 and the strobe bit are set in the same record.
- Assert reset_n low mid-run -> outputs 0 immediately. After release, no records until CTRL is rewritten.

Source files
------------

// File: rtl/apd_timer_pkg.sv
// Shared constants and types for the APD time-tagger: register map, CTRL layout,
// default geometry and record field offsets.
package apd_timer_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned TS_W  = 38;
  localparam int unsigned REC_W = TS_W + 2 * N_CH + 1;

  localparam logic [15:0] REG_CTRL      = 16'h0003;
  localparam logic [15:0] REG_STROBE_EN = 16'h0004;
  localparam logic [15:0] REG_DELTA_EN  = 16'h0005;

  localparam int unsigned CTRL_RUN_BIT   = 0;
  localparam int unsigned CTRL_EVEN_BIT  = 1;
  localparam int unsigned CTRL_CRST_BIT  = 2;

  localparam int unsigned REC_TS_LSB     = 0;
  localparam int unsigned REC_STROBE_LSB = TS_W;
  localparam int unsigned REC_DELTA_LSB  = TS_W + N_CH;
  localparam int unsigned REC_WRAP_BIT   = TS_W + 2 * N_CH;

  // Packed so that field order matches CTRL bit indices (run is bit 0).
  typedef struct packed {
    logic counter_reset;
    logic events_en;
    logic counter_run;
  } ctrl_t;

endpackage

// File: rtl/apd_input_cond.sv
// Per-channel detector conditioning: 2-FF synchroniser, previous-value register,
// and registered rise/level-change flags.
module apd_input_cond #(
  parameter int unsigned N_CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] strobe_i,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] change_o
);

  logic [N_CH-1:0] meta_q, sync_q, prev_q, rise_q, change_q;

  // Rise/change are registered so the event cycle lands two edges after the
  // first sampling edge, giving the three-edge strobe-to-record latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      rise_q   <= '0;
      change_q <= '0;
    end else begin
      meta_q   <= strobe_i;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      rise_q   <= sync_q & ~prev_q;
      change_q <= sync_q ^ prev_q;
    end
  end

  assign rise_o   = rise_q;
  assign change_o = change_q;

endmodule

// File: rtl/apd_timer_all.sv
// Four-channel APD photon time-tagger: free-running timestamp counter, register
// bus configuration and one record per event cycle (strobe, delta, wrap).
module apd_timer_all
  import apd_timer_pkg::*;
#(
  parameter int unsigned N_CH  = apd_timer_pkg::N_CH,
  parameter int unsigned TS_W  = apd_timer_pkg::TS_W,
  parameter int unsigned REC_W = TS_W + 2 * N_CH + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  strobe_in,
  input  logic [15:0]      reg_addr,
  input  logic [31:0]      reg_data,
  input  logic             reg_wr,
  output logic             record_rdy,
  output logic [REC_W-1:0] record
);

  ctrl_t             ctrl_q;
  logic [N_CH-1:0]   strobe_en_q, delta_en_q;
  logic [TS_W-1:0]   cnt_q;
  logic              wrap_q;
  logic              rdy_q;
  logic [REC_W-1:0]  rec_q;

  logic [N_CH-1:0]   rise, change;
  logic [N_CH-1:0]   strobe_bits, delta_bits;
  logic              event_d;
  logic [REC_W-1:0]  rec_d;
  logic              unused_data;

  assign unused_data = ^reg_data;

  apd_input_cond #(.N_CH(N_CH)) u_cond (
    .clk      (clk),
    .rst_n    (reset_n),
    .strobe_i (strobe_in),
    .rise_o   (rise),
    .change_o (change)
  );

  always_comb begin
    strobe_bits = rise & strobe_en_q;
    delta_bits  = change & delta_en_q;
    event_d     = ctrl_q.events_en && !ctrl_q.counter_reset &&
                  ((|strobe_bits) || (|delta_bits) || wrap_q);
    rec_d       = {wrap_q, delta_bits, strobe_bits, cnt_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      strobe_en_q <= '0;
      delta_en_q  <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      rdy_q       <= 1'b0;
      rec_q       <= '0;
    end else begin
      if (reg_wr) begin
        unique case (reg_addr)
          REG_CTRL:      ctrl_q      <= ctrl_t'(reg_data[2:0]);
          REG_STROBE_EN: strobe_en_q <= reg_data[N_CH-1:0];
          REG_DELTA_EN:  delta_en_q  <= reg_data[N_CH-1:0];
          default: ;
        endcase
      end

      // wrap_q marks the single cycle in which the counter reads 0 after rolling over.
      if (ctrl_q.counter_reset) begin
        cnt_q  <= '0;
        wrap_q <= 1'b0;
      end else if (ctrl_q.counter_run) begin
        cnt_q  <= cnt_q + TS_W'(1);
        wrap_q <= &cnt_q;
      end else begin
        wrap_q <= 1'b0;
      end

      rdy_q <= event_d;
      if (event_d) rec_q <= rec_d;
    end
  end

  assign record_rdy = rdy_q;
  assign record     = rec_q;

endmodule

// File: tb/tb_apd_timer_all.sv
// Scoreboard bench for apd_timer_all (reduced timestamp width so wrap is reachable).
module tb_apd_timer_all;

  localparam int unsigned NC = 4;
  localparam int unsigned TW = 10;
  localparam int unsigned RW = TW + 2 * NC + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NC-1:0] strobe_in;
  logic [15:0]   reg_addr;
  logic [31:0]   reg_data;
  logic          reg_wr;
  logic          record_rdy;
  logic [RW-1:0] record;

  always #2 clk = ~clk;

  apd_timer_all #(.N_CH(NC), .TS_W(TW), .REC_W(RW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .strobe_in  (strobe_in),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .reg_wr     (reg_wr),
    .record_rdy (record_rdy),
    .record     (record)
  );

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  int unsigned   cyc   = 0;
  logic [TW-1:0] mcnt;
  logic [2:0]    m_ctrl;
  logic [3:0]    m_sen, m_den;
  bit            wrap_pend;
  logic [3:0]    lvl_prev;
  logic [RW-1:0] exp_q [int unsigned];

  function automatic void add_exp(input int unsigned k, input logic [RW-1:0] v);
    if (exp_q.exists(k)) exp_q[k] = exp_q[k] | v;
    else exp_q[k] = v;
  endfunction

  // Reference model of the register file, counter and wrap records.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt = '0; m_ctrl = '0; m_sen = '0; m_den = '0; wrap_pend = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (wrap_pend && m_ctrl[1] && !m_ctrl[2]) add_exp(cyc, {1'b1, {(RW-1){1'b0}}});
      wrap_pend = 0;
      if (m_ctrl[2]) mcnt = '0;
      else if (m_ctrl[0]) begin
        wrap_pend = (mcnt == '1);
        mcnt = mcnt + TW'(1);
      end
      if (reg_wr) begin
        if (reg_addr == 16'h0003) m_ctrl = reg_data[2:0];
        if (reg_addr == 16'h0004) m_sen  = reg_data[3:0];
        if (reg_addr == 16'h0005) m_den  = reg_data[3:0];
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_vec++;
      if (exp_q.exists(cyc)) begin
        if (record_rdy !== 1'b1 || record !== exp_q[cyc]) begin
          n_bad++;
          $display("FAIL record cyc=%0d got rdy=%b rec=%h want rdy=1 rec=%h",
                   cyc, record_rdy, record, exp_q[cyc]);
        end
        exp_q.delete(cyc);
      end else if (record_rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL spurious_rdy cyc=%0d got rdy=%b rec=%h want rdy=0", cyc, record_rdy, record);
      end
    end
  end

  task automatic chk(input string nm, input logic [RW:0] got, input logic [RW:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Drive one cycle of strobe levels; expected records are queued for edge +4.
  task automatic step(input logic [3:0] lvl);
    logic [3:0]    r, c, sb, db;
    logic [TW-1:0] ts;
    r  = lvl & ~lvl_prev;
    c  = lvl ^ lvl_prev;
    sb = r & m_sen;
    db = c & m_den;
    if (m_ctrl[1] && !m_ctrl[2] && (sb != 0 || db != 0)) begin
      ts = m_ctrl[0] ? mcnt + TW'(3) : mcnt;
      add_exp(cyc + 4, {1'b0, db, sb, ts});
    end
    strobe_in = lvl;
    lvl_prev  = lvl;
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    reg_addr = a; reg_data = d; reg_wr = 1'b1;
    step(lvl_prev);
    reg_wr = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(4'b0000);
  endtask

  task automatic wait_cnt(input logic [TW-1:0] target);
    bit hit;
    hit = 0;
    for (int unsigned i = 0; i < 1200; i++) begin
      if (mcnt == target) begin hit = 1; break; end
      step(4'b0000);
    end
    chk("wrap_wait", {{RW{1'b0}}, hit}, {{RW{1'b0}}, 1'b1});
  endtask

  initial begin
    logic [3:0] l;
    strobe_in = '0; reg_addr = '0; reg_data = '0; reg_wr = 1'b0;
    lvl_prev = '0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", {record_rdy, record}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    wr(16'h0004, 0); wr(16'h0005, 0); wr(16'h0003, 32'h4); wr(16'h0003, 0);
    wr(16'h0004, 32'hF); wr(16'h0003, 32'h3);
    wr(16'h0103, 32'h0);

    for (int unsigned c = 0; c < 400; c++) begin
      l = '0;
      l[0] = (c % 51) < 2;
      l[1] = (c % 9) < 2;
      step(l);
    end
    idle(6);

    step(4'b0100); idle(8);

    wr(16'h0003, 0);
    step(4'b0001); step(4'b0001); idle(8);
    wr(16'h0003, 32'h3); wr(16'h0004, 0);
    step(4'b0001); step(4'b0001); idle(8);

    wr(16'h0005, 32'h1);
    step(4'b0001); step(4'b0001); step(4'b0001); idle(8);

    wr(16'h0004, 32'hF); wr(16'h0005, 0);
    step(4'b0011); step(4'b0011); idle(8);

    wait_cnt(TW'(1021));
    step(4'b0001); step(4'b0001); idle(8);
    wait_cnt(TW'(1015));
    idle(12);

    step(4'b0010); step(4'b0010); idle(3);
    #1 reset_n = 1'b0;
    #1 chk("midrun_reset", {record_rdy, record}, '0);
    lvl_prev = '0; strobe_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step(4'b0001); step(4'b0001); idle(8);
    wr(16'h0004, 32'hF); wr(16'h0003, 32'h3);
    step(4'b0101); step(4'b0101); idle(8);

    chk("sb_drained", RW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
